// File: rtl/memsys_pkg.sv
// Shared memory-subsystem constants: default bus width and opcode field position.
package memsys_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int OPC_LSB    = 3;
endpackage

// File: rtl/mar_ir_regs_if.sv
// Bus C load interface into MAR/IR: enables, clear and data in; register contents out.
interface mar_ir_regs_if
   import memsys_pkg::*;
#(
   parameter int DW = DATA_WIDTH
);
   logic               sclr;
   logic               mar_ena;
   logic               ir_ena;
   logic [DW-1:0]      d;
   logic [DW-1:0]      ram_addr;
   logic [DW-OPC_LSB-1:0] instruction;

   modport master (
      output sclr, mar_ena, ir_ena, d,
      input  ram_addr, instruction
   );

   modport slave (
      input  sclr, mar_ena, ir_ena, d,
      output ram_addr, instruction
   );
endinterface

// File: rtl/en_reg.sv
// Generic load-enable register; rst and sclr both clear, and both beat the enable.
module en_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclr,
   input  logic             ena,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst || sclr) q <= '0;
      else if (ena)    q <= d;
   end
endmodule

// File: rtl/mar_ir_regs.sv
// MAR latches the full bus C word; IR latches its opcode field (low OPC_LSB bits dropped).
module mar_ir_regs
   import memsys_pkg::*;
#(
   parameter int DATA_WIDTH = memsys_pkg::DATA_WIDTH
) (
   input logic          clk,
   input logic          rst,
   mar_ir_regs_if.slave bus
);
   localparam int IR_WIDTH = DATA_WIDTH - OPC_LSB;

   en_reg #(.WIDTH(DATA_WIDTH)) u_mar (
      .clk  (clk),
      .rst  (rst),
      .sclr (bus.sclr),
      .ena  (bus.mar_ena),
      .d    (bus.d),
      .q    (bus.ram_addr)
   );

   en_reg #(.WIDTH(IR_WIDTH)) u_ir (
      .clk  (clk),
      .rst  (rst),
      .sclr (bus.sclr),
      .ena  (bus.ir_ena),
      .d    (bus.d[DATA_WIDTH-1:OPC_LSB]),
      .q    (bus.instruction)
   );
endmodule

// File: tb/tb_mar_ir_regs.sv
// Directed-vector bench for mar_ir_regs with hand-computed expectations.
module tb_mar_ir_regs;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   mar_ir_regs_if #(.DW(8)) bus ();

   mar_ir_regs #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one input vector, clock it in, then check both outputs mid-cycle.
   task automatic step(input string tag, input logic r, input logic sc, input logic me,
                       input logic ie, input logic [7:0] dv,
                       input logic [7:0] exp_addr, input logic [4:0] exp_ir);
      rst         = r;
      bus.sclr    = sc;
      bus.mar_ena = me;
      bus.ir_ena  = ie;
      bus.d       = dv;
      @(posedge clk);
      #1;
      chk({tag, ".addr"}, {24'd0, bus.ram_addr}, {24'd0, exp_addr});
      chk({tag, ".ir"},   {27'd0, bus.instruction}, {27'd0, exp_ir});
   endtask

   initial begin
      rst = 1'b1; bus.sclr = 1'b1; bus.mar_ena = 1'b0; bus.ir_ena = 1'b0; bus.d = 8'h00;
      @(negedge clk);
      //          tag          rst   sclr  mar   ir    d             addr          ir
      step("reset",      1'b1, 1'b1, 1'b0, 1'b0, 8'h00,        8'h00,        5'b00000);
      step("hold",       1'b0, 1'b0, 1'b0, 1'b0, 8'b01100000,  8'h00,        5'b00000);
      step("mar_load",   1'b0, 1'b0, 1'b1, 1'b0, 8'b00001100,  8'b00001100,  5'b00000);
      step("ir_load",    1'b0, 1'b0, 1'b0, 1'b1, 8'b11110000,  8'b00001100,  5'b11110);
      step("sclr_prio",  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF,        8'h00,        5'b00000);
      step("reload_mar", 1'b0, 1'b0, 1'b1, 1'b0, 8'b01110000,  8'b01110000,  5'b00000);
      step("reload_ir",  1'b0, 1'b0, 1'b0, 1'b1, 8'b00111100,  8'b01110000,  5'b00111);
      step("ir_lowbits", 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000111,  8'b01110000,  5'b00000);
      step("both_load",  1'b0, 1'b0, 1'b1, 1'b1, 8'hA5,        8'hA5,        5'b10100);
      step("held_ena",   1'b0, 1'b0, 1'b1, 1'b1, 8'h5A,        8'h5A,        5'b01011);
      step("rst_prio",   1'b1, 1'b0, 1'b1, 1'b1, 8'hFF,        8'h00,        5'b00000);
      step("post_rst",   1'b0, 1'b0, 1'b0, 1'b0, 8'hFF,        8'h00,        5'b00000);
      step("full_load",  1'b0, 1'b0, 1'b1, 1'b1, 8'hFF,        8'hFF,        5'b11111);
      step("sclr_only",  1'b0, 1'b1, 1'b0, 1'b0, 8'h3C,        8'h00,        5'b00000);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
